// File: rtl/datapath_param.sv
// Parametrised CPU datapath: register file, PC/IR/MAR/CCR/SP, and MDR via a req/ack memory port.
// Define STACK_GUARD_EN to add a sticky sp_err output and block SP wrap on push/pop.
//
// state   | meaning
// IDLE    | no memory transaction; register strobes honoured
// WAIT    | transaction pending (busy=1); all strobes ignored until mem_ack
module datapath_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NREG = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int SELW = $clog2(NREG + 2),
  localparam int RSELW = $clog2(NREG)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [SELW-1:0]   bus1_sel,
  input  logic [1:0]        bus2_sel,
  input  logic              reg_load,
  input  logic [RSELW-1:0]  reg_wsel,
  input  logic              pc_load,
  input  logic              pc_inc,
  input  logic              ir_load,
  input  logic              mar_load,
  input  logic              ccr_load,
  input  logic              sp_push,
  input  logic              sp_pop,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        nzvc,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic [DATA_W-1:0] bus1_out,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] mar,
`ifdef STACK_GUARD_EN
  output logic              sp_err,
`endif
  output logic [3:0]        ccr
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t              state, state_next;
  logic                start;
  logic [DATA_W-1:0]   regs [NREG];
  logic [DATA_W-1:0]   mdr;
  logic [DATA_W-1:0]   bus1, bus2;
  logic [ADDR_W-1:0]   sp_next;
  logic                sp_err_set;

  assign mem_req  = (state == ST_WAIT);
  assign busy     = mem_req;
  assign bus1_out = bus1;

  always_comb begin
    bus1 = '0;
    if (bus1_sel == SELW'(0))
      bus1 = DATA_W'(pc);
    else if (bus1_sel == SELW'(1))
      bus1 = DATA_W'(sp);
    else
      for (int k = 0; k < NREG; k++)
        if (bus1_sel == SELW'(k + 2))
          bus1 = regs[k];
  end

  always_comb begin
    bus2 = '0;
    case (bus2_sel)
      2'd0:    bus2 = alu_result;
      2'd1:    bus2 = bus1;
      2'd2:    bus2 = mdr;
      default: bus2 = '0;
    endcase
  end

  // Push and pop together cancel; the guard only trips on a lone push/pop at the limit.
  always_comb begin
    sp_next    = sp;
    sp_err_set = 1'b0;
    if (!busy) begin
      if (sp_push && !sp_pop) begin
`ifdef STACK_GUARD_EN
        if (sp == '0) sp_err_set = 1'b1;
        else          sp_next = sp - ADDR_W'(1);
`else
        sp_next = sp - ADDR_W'(1);
`endif
      end else if (sp_pop && !sp_push) begin
`ifdef STACK_GUARD_EN
        if (sp == '1) sp_err_set = 1'b1;
        else          sp_next = sp + ADDR_W'(1);
`else
        sp_next = sp + ADDR_W'(1);
`endif
      end
    end
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_rd || mem_wr) begin
          start      = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_ack) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      sp        <= '1;
      ir        <= '0;
      mar       <= '0;
      mdr       <= '0;
      ccr       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      for (int k = 0; k < NREG; k++) regs[k] <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        mem_addr <= mar;
        mem_we   <= ~mem_rd;
        if (!mem_rd) mem_wdata <= bus1;
      end
      if (state == ST_WAIT && mem_ack && !mem_we)
        mdr <= mem_rdata;
      if (!busy) begin
        if (reg_load) regs[reg_wsel] <= bus2;
        if (pc_load)     pc <= bus2[ADDR_W-1:0];
        else if (pc_inc) pc <= pc + ADDR_W'(1);
        if (ir_load)  ir  <= bus2;
        if (mar_load) mar <= bus2[ADDR_W-1:0];
        if (ccr_load) ccr <= nzvc;
      end
      sp <= sp_next;
    end
  end

`ifdef STACK_GUARD_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          sp_err <= 1'b0;
    else if (sp_err_set) sp_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_datapath_param.sv
// Directed bench for datapath_param (DATA_W=ADDR_W=8, NREG=4, RESET_PC=8'h10).
module tb_datapath_param;
  logic       clock, reset;
  logic [2:0] bus1_sel;
  logic [1:0] bus2_sel, reg_wsel;
  logic       reg_load, pc_load, pc_inc, ir_load, mar_load, ccr_load;
  logic       sp_push, sp_pop, mem_rd, mem_wr, mem_ack;
  logic [7:0] alu_result, mem_rdata;
  logic [3:0] nzvc;
  logic       mem_req, mem_we, busy;
  logic [7:0] mem_addr, mem_wdata, bus1_out, ir, pc, sp, mar;
  logic [3:0] ccr;
`ifdef STACK_GUARD_EN
  logic       sp_err;
`endif

  int checks = 0;
  int errors = 0;

  datapath_param #(.DATA_W(8), .ADDR_W(8), .NREG(4), .RESET_PC(8'h10)) dut (
    .clock(clock), .reset(reset), .bus1_sel(bus1_sel), .bus2_sel(bus2_sel),
    .reg_load(reg_load), .reg_wsel(reg_wsel), .pc_load(pc_load), .pc_inc(pc_inc),
    .ir_load(ir_load), .mar_load(mar_load), .ccr_load(ccr_load),
    .sp_push(sp_push), .sp_pop(sp_pop), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .alu_result(alu_result), .nzvc(nzvc), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .bus1_out(bus1_out), .ir(ir), .pc(pc), .sp(sp), .mar(mar),
`ifdef STACK_GUARD_EN
    .sp_err(sp_err),
`endif
    .ccr(ccr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_strobes();
    reg_load = 0; pc_load = 0; pc_inc = 0; ir_load = 0; mar_load = 0; ccr_load = 0;
    sp_push = 0; sp_pop = 0; mem_rd = 0; mem_wr = 0; mem_ack = 0;
  endtask

  initial begin
    clear_strobes();
    bus1_sel = 0; bus2_sel = 0; reg_wsel = 0;
    alu_result = 0; mem_rdata = 0; nzvc = 0;
    reset = 1;
    #2 reset = 0;
    step(); step();
    check("rst_pc", pc, 8'h10);
    check("rst_sp", sp, 8'hFF);
    check("rst_ir", ir, 0);
    check("rst_ccr", ccr, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mar", mar, 0);
    reset = 1;

    // register move R2 <- alu, IR <- R2 via Bus1/Bus2
    alu_result = 8'h5A; bus2_sel = 0; reg_load = 1; reg_wsel = 2;
    step(); clear_strobes();
    bus1_sel = 4; #1;
    check("bus1_r2", bus1_out, 8'h5A);
    bus2_sel = 1; ir_load = 1;
    step(); clear_strobes();
    check("ir_move", ir, 8'h5A);

    nzvc = 4'b1010; ccr_load = 1;
    step(); clear_strobes();
    check("ccr_load", ccr, 4'hA);

    // PC wrap and load-over-inc
    alu_result = 8'hFF; bus2_sel = 0; pc_load = 1;
    step(); clear_strobes();
    check("pc_load_ff", pc, 8'hFF);
    pc_inc = 1;
    step(); clear_strobes();
    check("pc_wrap", pc, 8'h00);
    alu_result = 8'h33; pc_load = 1; pc_inc = 1;
    step(); clear_strobes();
    check("pc_load_beats_inc", pc, 8'h33);
    bus1_sel = 0; #1;
    check("bus1_pc", bus1_out, 8'h33);

    // read with 3 WAIT cycles; pc_inc held throughout is ignored
    alu_result = 8'h40; mar_load = 1;
    step(); clear_strobes();
    check("mar_load", mar, 8'h40);
    mem_rd = 1;
    step(); clear_strobes();
    pc_inc = 1;
    check("rd_busy1", busy, 1);
    check("rd_req", mem_req, 1);
    check("rd_addr", mem_addr, 8'h40);
    check("rd_we", mem_we, 0);
    step();
    check("rd_busy2", busy, 1);
    step();
    check("rd_busy3", busy, 1);
    mem_ack = 1; mem_rdata = 8'hC3;
    step(); clear_strobes();
    check("rd_done", busy, 0);
    check("pc_held_in_wait", pc, 8'h33);
    bus2_sel = 2; ir_load = 1;
    step(); clear_strobes();
    check("mdr_read", ir, 8'hC3);

    // ack in IDLE must not touch MDR
    mem_ack = 1; mem_rdata = 8'hEE;
    step(); clear_strobes();
    check("idle_ack_busy", busy, 0);
    bus2_sel = 2; reg_load = 1; reg_wsel = 1;
    step(); clear_strobes();
    bus1_sel = 3; #1;
    check("idle_ack_mdr", bus1_out, 8'hC3);

    // write with zero-wait ack
    alu_result = 8'h77; bus2_sel = 0; reg_load = 1; reg_wsel = 0;
    step(); clear_strobes();
    alu_result = 8'h20; mar_load = 1;
    step(); clear_strobes();
    bus1_sel = 2; mem_wr = 1;
    step(); clear_strobes();
    check("wr_we", mem_we, 1);
    check("wr_wdata", mem_wdata, 8'h77);
    check("wr_addr", mem_addr, 8'h20);
    check("wr_busy", busy, 1);
    mem_ack = 1;
    step(); clear_strobes();
    check("wr_done", busy, 0);
    bus2_sel = 2; ir_load = 1; ir_load = 1;
    alu_result = 8'h00;
    step(); clear_strobes();
    check("wr_mdr_kept", ir, 8'hC3);

    // read beats write; a load strobed with the start still lands
    mem_rd = 1; mem_wr = 1; nzvc = 4'h5; ccr_load = 1;
    step(); clear_strobes();
    check("rdwr_we", mem_we, 0);
    check("start_ccr", ccr, 4'h5);
    mem_ack = 1; mem_rdata = 8'h96;
    step(); clear_strobes();
    check("rdwr_done", busy, 0);

    // stack
    sp_push = 1;
    step(); clear_strobes();
    check("sp_push", sp, 8'hFE);
    bus1_sel = 1; sp_pop = 1; #1;
    check("bus1_sp_pre", bus1_out, 8'hFE);
    step(); clear_strobes();
    check("sp_pop", sp, 8'hFF);
    sp_push = 1; sp_pop = 1;
    step(); clear_strobes();
    check("sp_both", sp, 8'hFF);
`ifdef STACK_GUARD_EN
    check("sp_err_init", sp_err, 0);
    sp_pop = 1;
    step(); clear_strobes();
    check("guard_sp", sp, 8'hFF);
    check("guard_err", sp_err, 1);
    sp_push = 1;
    step(); clear_strobes();
    check("guard_push_ok", sp, 8'hFE);
    check("guard_sticky", sp_err, 1);
    sp_pop = 1;
    step(); clear_strobes();
`else
    sp_pop = 1;
    step(); clear_strobes();
    check("sp_wrap_pop", sp, 8'h00);
    sp_push = 1;
    step(); clear_strobes();
    check("sp_wrap_push", sp, 8'hFF);
`endif

    // reset during WAIT aborts the transaction
    mem_rd = 1;
    step(); clear_strobes();
    check("abort_busy", busy, 1);
    reset = 0; #1;
    check("abort_req", mem_req, 0);
    check("abort_pc", pc, 8'h10);
    check("abort_sp", sp, 8'hFF);
    step();
    reset = 1;
    mem_ack = 1; mem_rdata = 8'h5C;
    step(); clear_strobes();
    check("abort_ack_ignored", mem_req, 0);
    bus2_sel = 2; ir_load = 1;
    step(); clear_strobes();
    check("abort_mdr", ir, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/datapath_param.md
Name: datapath_param

Overview:
- Parametrised CPU datapath, the next generation of the fixed 8-bit A/B datapath.
- Contents:
  - NREG-entry general register file.
  - Program counter (PC), instruction register (IR), memory address register (MAR), condition-code register (CCR) and stack pointer (SP).
  - Memory data register (MDR) captured through a req/ack memory handshake with wait states.
- Sits between the control FSM, the ALU and the memory port.
- The control FSM drives one-cycle strobes and watches busy.

Parameters:
- DATA_W, 8: data/register width, must be >= 4.
- ADDR_W, 8: address, PC, MAR and SP width; ADDR_W <= DATA_W.
- NREG, 4: general registers R0..R(NREG-1); power of 2, 2..16.
- RESET_PC, 0: PC value after reset.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- bus1_sel  in  SELW=$clog2(NREG+2)  Bus1 source: 0=PC, 1=SP, 2+k=R[k].
- bus2_sel  in  2  Bus2 source: 0=alu_result, 1=Bus1, 2=MDR, 3=zero.
- reg_load  in  1  write Bus2 into R[reg_wsel].
- reg_wsel  in  $clog2(NREG)  destination register.
- pc_load, pc_inc, ir_load, mar_load, ccr_load  in  1 each  register load strobes.
- sp_push, sp_pop  in  1 each  stack pointer adjust.
- mem_rd, mem_wr  in  1 each  start a memory transaction.
- alu_result  in  DATA_W  ALU output.
- nzvc  in  4  flags from the ALU.
- mem_rdata  in  DATA_W  memory read data.
- mem_ack  in  1  memory completion, one-cycle pulse.
- mem_req  out  1  transaction pending.
- mem_we  out  1  1 = write transaction.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- busy  out  1  equals mem_req.
- bus1_out  out  DATA_W  Bus1 value, for the ALU A operand.
- ir, pc, sp, mar  out  DATA_W/ADDR_W  register contents.
- ccr  out  4  register contents.

Behaviour:
- Reset (async, active-low): PC=RESET_PC, SP=all-ones, all R, IR, MAR, MDR and CCR = 0; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset mid-transaction aborts it; a later mem_ack is ignored.
- Bus1 / Bus2:
  - Both are combinational.
  - ADDR_W sources are zero-extended to DATA_W.
  - bus1_sel >= NREG+2 gives Bus1=0.
- Register writes:
  - Loads take effect on the rising edge when busy=0.
  - Narrower destinations (PC, MAR) take Bus2[ADDR_W-1:0].
- PC: pc_load beats pc_inc; pc_inc gives PC+1, modulo 2^ADDR_W (all-ones wraps to 0).
- SP (pre-decrement push, post-increment pop):
  - sp_push gives SP-1; sp_pop gives SP+1, both modulo 2^ADDR_W.
  - push and pop together: SP unchanged.
  - Bus1 with sel=1 shows the current (pre-update) SP.
- CCR: ccr_load captures nzvc.
- Simultaneous strobes to different registers all take effect in the same cycle.
- Memory FSM, states IDLE and WAIT:
  - IDLE -> WAIT when mem_rd or mem_wr is asserted. On entry: mem_addr<=MAR, mem_we<=~mem_rd, mem_wdata<=Bus1 (write only), mem_req<=1.
  - mem_rd and mem_wr together: the read wins.
  - Register loads strobed in the same cycle as the start still occur, because busy is still 0.
  - WAIT: busy=1; all load, inc, push, pop, mem_rd and mem_wr strobes are ignored; the control FSM must hold.
  - WAIT -> IDLE on mem_ack. Reads capture mem_rdata into MDR on the same edge.
  - MDR is visible on Bus2 (sel=2) from the next cycle.
  - mem_req drops the cycle after ack, so the minimum transaction is 2 cycles (start edge, ack edge).
  - mem_ack in IDLE is ignored.
  - Zero-wait memory (ack in the first WAIT cycle) is legal.

Optional Feature:
- Macro STACK_GUARD_EN.
- Defined:
  - Extra output sp_err (1 bit, reset 0).
  - A push with SP==0 or a pop with SP==all-ones leaves SP unchanged and sets sp_err.
  - sp_err is sticky until reset.
- Undefined: no sp_err port; SP wraps modulo 2^ADDR_W.

Test Plan:
- Reset: release reset with RESET_PC=8'h10 -> pc=8'h10, sp=8'hFF, ir=0, ccr=0, mem_req=0; assert reset mid-WAIT -> mem_req=0 asynchronously.
- Register move: alu_result=8'h5A, bus2_sel=0, reg_load, reg_wsel=2 -> R2=8'h5A; then bus1_sel=4, bus2_sel=1, ir_load -> ir=8'h5A.
- PC: pc=8'hFF with pc_inc -> 8'h00; pc_load and pc_inc together with Bus2=8'h33 -> pc=8'h33.
- Read with wait states: mar=8'h40, mem_rd, ack after 3 WAIT cycles, mem_rdata=8'hC3.
  - mem_addr=8'h40, mem_we=0, busy=1 for 3 cycles.
  - A pc_inc held during WAIT is ignored.
  - MDR=8'hC3 via bus2_sel=2.
- Write: bus1_sel=2 (R0=8'h77), mem_wr with mar=8'h20 -> mem_we=1, mem_wdata=8'h77, mem_addr=8'h20; zero-wait ack -> busy low after 2 cycles.
- Stack:
  - Push from 8'hFF -> 8'hFE; pop -> 8'hFF; push and pop together -> unchanged.
  - STACK_GUARD_EN defined: pop at 8'hFF -> sp=8'hFF, sp_err=1 and stays 1.
